// File: rtl/prbs31_checker.sv
// PRBS-31 (x^31 + x^28 + 1) serial receive checker.
// Self-synchronises on the received stream, declares lock, then counts bit errors against a
// free-running local reference.
// Optional build macro PRBS31_CHK_AUTO_UNLOCK_EN: windowed error monitor that drops lock when
// UNLOCK_ERR errors land inside one WIN_LEN-sample window. Without it, LOCKED is left only
// through reset or resync.
module prbs31_checker #(
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned LOCK_CNT   = 64,
  parameter int unsigned WIN_LEN    = 1024,
  parameter int unsigned UNLOCK_ERR = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             resync,
  input  logic             clear_cnt,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count
);

  typedef enum logic [0:0] {StSearch, StLocked} state_e;

  localparam logic [7:0]       LockCntV = 8'(LOCK_CNT);
  localparam logic [CNT_W-1:0] CntMax   = '1;

  state_e      state_q;
  logic [30:0] hist_q;
  logic [4:0]  fill_q;
  logic [7:0]  match_q;

  logic exp_bit;
  logic hist_zero;
  logic search_miss;
  logic lock_err;
  logic unlock;

  // Reference bit and per-sample compare results
  always_comb begin
    exp_bit     = hist_q[30] ^ hist_q[27];
    hist_zero   = (hist_q == '0);
    // An all-zero history is the LFSR lock-up state; never let it count as a match.
    search_miss = (in_bit != exp_bit) || hist_zero;
    lock_err    = in_valid && (state_q == StLocked) && (in_bit != exp_bit);
  end

`ifdef PRBS31_CHK_AUTO_UNLOCK_EN
  localparam int unsigned WinW  = $clog2(WIN_LEN + 1);
  localparam int unsigned WerrW = $clog2(UNLOCK_ERR + 1);

  logic [WinW-1:0]  win_q;
  logic [WerrW-1:0] win_err_q;
  logic [WerrW-1:0] win_err_next;

  // Error total including the current sample, so a closing-sample error still counts
  always_comb begin
    win_err_next = win_err_q + WerrW'(lock_err);
    unlock       = lock_err && (win_err_next == WerrW'(UNLOCK_ERR));
  end

  // Window position and error tally; held at zero while searching so a fresh lock starts clean
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      win_q     <= '0;
      win_err_q <= '0;
    end else if (state_q == StSearch) begin
      win_q     <= '0;
      win_err_q <= '0;
    end else if (in_valid) begin
      if (win_q == WinW'(WIN_LEN - 1)) begin
        win_q     <= '0;
        win_err_q <= '0;
      end else begin
        win_q     <= win_q + 1'b1;
        win_err_q <= win_err_next;
      end
    end
  end
`else
  logic unused_win_cfg;

  assign unlock         = 1'b0;
  assign unused_win_cfg = ^{WIN_LEN, UNLOCK_ERR};
`endif

  // Search/lock FSM with history register, counters and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StSearch;
      hist_q    <= '0;
      fill_q    <= '0;
      match_q   <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      err_count <= '0;
    end else begin
      err_pulse <= lock_err;
      if (clear_cnt) begin
        err_count <= '0;
      end else if (lock_err && (err_count != CntMax)) begin
        err_count <= err_count + 1'b1;
      end

      if (resync) begin
        state_q <= StSearch;
        locked  <= 1'b0;
        fill_q  <= '0;
        match_q <= '0;
      end else if (in_valid) begin
        unique case (state_q)
          StSearch: begin
            hist_q <= {hist_q[29:0], in_bit};
            if (fill_q != 5'd31) begin
              fill_q <= fill_q + 1'b1;
            end else if (search_miss) begin
              match_q <= '0;
            end else if (match_q + 8'd1 == LockCntV) begin
              state_q <= StLocked;
              locked  <= 1'b1;
              match_q <= '0;
            end else begin
              match_q <= match_q + 1'b1;
            end
          end
          StLocked: begin
            // Free-running reference: a flipped input bit must not pollute the history.
            hist_q <= {hist_q[29:0], exp_bit};
            if (unlock) begin
              state_q <= StSearch;
              locked  <= 1'b0;
              fill_q  <= '0;
              match_q <= '0;
            end
          end
          default: state_q <= StSearch;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prbs31_checker.sv
// Bench for prbs31_checker: drives a seeded PRBS-31 stream with planted bit flips into a default
// instance and a 4-bit-counter instance; a spec-level model queues expected outputs per cycle.
module tb_prbs31_checker;

  localparam int unsigned LockSamples = 95;  // 31 fill samples + LOCK_CNT matches
  localparam int unsigned WinLen      = 1024;
  localparam int unsigned UnlockErr   = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_bit = 1'b0;
  logic        resync = 1'b0;
  logic        clear_cnt = 1'b0;
  logic        locked, err_pulse;
  logic [31:0] err_count;
  logic        locked_s, err_pulse_s;
  logic [3:0]  err_count_s;

  always #5 clk = ~clk;

  prbs31_checker dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_bit    (in_bit),
    .resync    (resync),
    .clear_cnt (clear_cnt),
    .locked    (locked),
    .err_pulse (err_pulse),
    .err_count (err_count)
  );

  prbs31_checker #(
    .CNT_W (4)
  ) dut_sat (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_bit    (in_bit),
    .resync    (resync),
    .clear_cnt (clear_cnt),
    .locked    (locked_s),
    .err_pulse (err_pulse_s),
    .err_count (err_count_s)
  );

  typedef struct packed {
    logic        lk;
    logic        pl;
    logic [31:0] cnt;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int unsigned n_checks = 0;
  int unsigned n_pass = 0;

  // Stimulus generator and spec-level model state
  logic [30:0] gen;
  bit          zero_mode;
  bit          m_locked;
  int unsigned m_run, m_win, m_win_err;
  logic [31:0] m_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // One cycle of stimulus; the model predicts the outputs seen after the next rising edge
  task automatic step(input bit v, input bit flip = 1'b0, input bit clr = 1'b0,
                      input bit rs = 1'b0);
    bit   b, e;
    exp_t x;
    @(negedge clk);
    b = 1'b0;
    if (v && !zero_mode) begin
      b   = gen[30] ^ gen[27];
      gen = {gen[29:0], b};
    end
    b         = b ^ (v & flip);
    in_valid  = v;
    in_bit    = b;
    clear_cnt = clr;
    resync    = rs;

    e = v && flip && m_locked;
    if (clr) m_err = '0;
    else if (e) m_err = m_err + 1;
    if (rs) begin
      m_locked = 1'b0;
      m_run    = 0;
    end else if (v) begin
      if (m_locked) begin
        m_win++;
        if (e) m_win_err++;
`ifdef PRBS31_CHK_AUTO_UNLOCK_EN
        if (e && m_win_err == UnlockErr) begin
          m_locked = 1'b0;
          m_run    = 0;
        end
`endif
        if (m_win == WinLen) begin
          m_win     = 0;
          m_win_err = 0;
        end
      end else if (!zero_mode) begin
        m_run++;
        if (m_run == LockSamples) begin
          m_locked  = 1'b1;
          m_win     = 0;
          m_win_err = 0;
        end
      end else begin
        m_run = 0;
      end
    end
    x.lk  = m_locked;
    x.pl  = e;
    x.cnt = m_err;
    sb_q.push_back(x);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear before any clock edge
  task automatic do_reset();
    @(negedge clk);
    #2;
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_bit    = 1'b0;
    resync    = 1'b0;
    clear_cnt = 1'b0;
    #1;
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_err_pulse", 32'(err_pulse), 32'd0);
    check("rst_err_count", err_count, 32'd0);
    check("rst_locked_sat", 32'(locked_s), 32'd0);
    check("rst_err_pulse_sat", 32'(err_pulse_s), 32'd0);
    check("rst_err_count_sat", 32'(err_count_s), 32'd0);
    gen       = 31'd1;
    m_locked  = 1'b0;
    m_run     = 0;
    m_win     = 0;
    m_win_err = 0;
    m_err     = '0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Scoreboard: compare both instances against the queued prediction
  always @(posedge clk) begin
    #1;
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      check("locked", 32'(locked), 32'(mon_e.lk));
      check("err_pulse", 32'(err_pulse), 32'(mon_e.pl));
      check("err_count", err_count, mon_e.cnt);
      check("locked_sat", 32'(locked_s), 32'(mon_e.lk));
      check("err_pulse_sat", 32'(err_pulse_s), 32'(mon_e.pl));
      check("err_count_sat", 32'(err_count_s), (mon_e.cnt > 32'd15) ? 32'd15 : mon_e.cnt);
    end
  end

  initial begin
    #950000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation did not complete");
  end

  initial begin
    int unsigned cnt_v, errs;
    bit          v, f;

    // All-zero stream must never lock
    do_reset();
    zero_mode = 1'b1;
    repeat (200) step(1'b1);

    // Clean PRBS-31 from seed 1: lock after sample 95, no errors over 10000 bits
    do_reset();
    zero_mode = 1'b0;
    repeat (10000) step(1'b1);

    // One flipped bit while locked gives exactly one error
    for (int i = 1; i <= 1000; i++) step(1'b1, (i == 500));

    // 16 flips inside one window, starting on a window boundary
    for (int i = 0; i < 1100 && m_win != 0; i++) step(1'b1);
    check("window_aligned", m_win, 32'd0);
    for (int k = 0; k < 16; k++) begin
      step(1'b1, 1'b1);
      repeat (7) step(1'b1);
    end
    repeat (150) step(1'b1);

    // resync drops lock; clean stream relocks
    step(1'b0, 1'b0, 1'b0, 1'b1);
    repeat (100) step(1'b1);

    // clear_cnt on the error's update cycle wins over the increment
    step(1'b1, 1'b1, 1'b1);
    repeat (5) step(1'b1);

    // 50% valid: relock, then 20 isolated errors saturate the 4-bit counter
    step(1'b0, 1'b0, 1'b0, 1'b1);
    cnt_v = 0;
    errs  = 0;
    for (int i = 0; i < 60000 && errs < 20; i++) begin
      v = 1'($urandom_range(0, 1));
      f = 1'b0;
      if (v) begin
        cnt_v++;
        if (cnt_v > 200 && (cnt_v - 200) % 1100 == 0) begin
          f = 1'b1;
          errs++;
        end
      end
      step(v, f);
    end
    check("errors_injected", errs, 32'd20);
    repeat (10) step(1'b1);

    // Async reset while locked with err_pulse high
    step(1'b1, 1'b1);
    do_reset();
    repeat (3) step(1'b0);
    @(negedge clk);
    check("sb_drained", sb_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
